seg_capture: RTL
================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 an  input  4  multiplexed display anodes, active-low; an[i] low selects digit i, where digit 3 is the leftmost.
REQ-005 seg  input  8  display cathodes, active-low; seg[0..6] = segments a..g, seg[7] = dp.
REQ-006 value  output  16  last complete frame, one hex nibble per digit; value[4i+3:4i] = digit i.
REQ-007 dp_out  output  4  last complete frame's decimal points; dp_out[i] = digit i, active-high.
REQ-008 valid  output  1  one-cycle pulse when value/dp_out are updated.
REQ-009 err  output  1  one-cycle pulse when a captured pattern does not decode.

Function
REQ-010 an and seg shall each pass through a 2-flop synchronizer before any other logic uses them.
REQ-011 A sample is eligible only when exactly one an bit is low; all-high or multiple-low samples shall clear the stability counter and return the FSM to WAIT.
REQ-012 FSM states: WAIT (counting stability) and HELD (digit captured, awaiting change).
- WAIT: the counter increments while the {an,seg} sample equals the previous one and reloads to 1 on change.
- When the counter reaches STABLE_CYCLES, the digit is captured and the FSM enters HELD.
- HELD: any change of {an,seg} shall reload the counter to 1 and enter WAIT, so each dwell captures at most once.
REQ-013 Decode table for seg[6:0], active-low, standard hex glyphs:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- blank 7F decodes to nibble 0.
REQ-014 An unlisted pattern shall pulse err for one cycle, leave that digit's staging nibble unchanged and clear that digit's bit in the seen mask.
REQ-015 A successful capture shall write the staging nibble and the staging dp bit, and set seen[i].
REQ-016 When seen becomes 4'b1111, on the next edge:
- value and dp_out load from staging;
- valid pulses for one cycle;
- seen clears to 0.
REQ-017 Recapturing a digit already in seen shall overwrite its staging entry without affecting completion.
REQ-018 Capture and frame completion in the same cycle as an err: err takes priority for that digit; no valid pulse that cycle.
REQ-019 Counter width 8 bits; it saturates at STABLE_CYCLES and never wraps.

Reset
REQ-020 With rst_n low, the following shall be 0 asynchronously:
- value, dp_out, valid, err;
- staging, seen, counter, synchronizer flops.
- The FSM shall be in WAIT.
REQ-021 Reset asserted mid-frame shall discard partial staging; the first valid after release requires four fresh captures.

Configuration
REQ-022 Macro SEG_CAPTURE_DP_EN:
- Defined: seg[7] is captured per digit, and dp_out reflects ~seg[7] of the captured sample.
- Undefined: seg[7] is excluded from the stability compare, and dp_out is constant 0.

Verification
REQ-023 Scan an=0111/1011/1101/1110 with seg=79/24/30/40, each held 8 cycles -> one valid pulse, value=16'h1230, err never asserted.
REQ-024 Same scan with each digit held 3 cycles (STABLE_CYCLES=4) -> no valid, value stays 16'h0000.
REQ-025 Digit 2 driven with 7'h7E (segment a only lit), other digits valid -> err pulses once, no valid; next clean scan -> valid.
REQ-026 an=1110 seg=00 held 40 cycles -> exactly one capture; an=0000 glitch between digits -> counter resets, no capture.
REQ-027 rst_n pulsed low after three digits of a frame -> outputs 0 immediately; a fourth digit alone yields no valid.
REQ-028 With SEG_CAPTURE_DP_EN, digit 0 shown with seg=8'h40 (dp lit) in a full scan -> dp_out=4'b0001; without the macro -> dp_out=4'b0000.

Source files
------------

// File: rtl/seg_capture.sv
// Recovers the digits shown on a multiplexed, active-low 7-segment display and
// emits one complete 4-digit frame at a time. Decimal-point capture is enabled
// by defining SEG_CAPTURE_DP_EN.
module seg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] value,
    output logic [3:0]  dp_out,
    output logic        valid,
    output logic        err
);
`ifdef SEG_CAPTURE_DP_EN
    localparam int KW = 12;
`else
    localparam int KW = 11;
`endif
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic {WAIT, HELD} state_t;

    logic [3:0]      an_s1_q, an_s2_q;
    logic [7:0]      seg_s1_q, seg_s2_q;
    logic [KW-1:0]   key, prev_q;
    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0][3:0] stage_q, stage_d;
    logic [3:0]      seen_q, seen_d;
    logic [15:0]     value_q, value_d;
    logic            valid_q, valid_d, err_q, err_d;
    logic            elig, cap, dec_ok;
    logic [1:0]      idx;
    logic [3:0]      dec_nib;

`ifdef SEG_CAPTURE_DP_EN
    logic [3:0] stage_dp_q, stage_dp_d, dp_q, dp_d;
    assign key = {an_s2_q, seg_s2_q};
`else
    logic unused_dp;
    assign unused_dp = seg_s2_q[7];
    assign key = {an_s2_q, seg_s2_q[6:0]};
`endif

    always_comb begin
        elig = 1'b1;
        idx  = 2'd0;
        case (an_s2_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: elig = 1'b0;
        endcase
    end

    always_comb begin
        dec_ok  = 1'b1;
        dec_nib = 4'h0;
        case (seg_s2_q[6:0])
            7'h40: dec_nib = 4'h0;  7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;  7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;  7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;  7'h78: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;  7'h10: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;  7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;  7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;  7'h0E: dec_nib = 4'hF;
            7'h7F: dec_nib = 4'h0;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        seen_d  = seen_q;
        value_d = value_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        cap     = 1'b0;
`ifdef SEG_CAPTURE_DP_EN
        stage_dp_d = stage_dp_q;
        dp_d       = dp_q;
`endif
        if (!elig) begin
            cnt_d   = 8'd0;
            state_d = WAIT;
        end else if (key != prev_q) begin
            cnt_d   = 8'd1;
            state_d = WAIT;
        end else if (state_q == WAIT) begin
            if (cnt_q < STABLE) cnt_d = cnt_q + 8'd1;
            if (cnt_d == STABLE) begin
                cap     = 1'b1;
                state_d = HELD;
            end
        end

        // A decode error in the completion cycle holds the frame back.
        if (seen_q == 4'hF && !(cap && !dec_ok)) begin
            value_d = stage_q;
            valid_d = 1'b1;
            seen_d  = 4'h0;
`ifdef SEG_CAPTURE_DP_EN
            dp_d    = stage_dp_q;
`endif
        end

        if (cap) begin
            if (dec_ok) begin
                stage_d[idx] = dec_nib;
                seen_d[idx]  = 1'b1;
`ifdef SEG_CAPTURE_DP_EN
                stage_dp_d[idx] = ~seg_s2_q[7];
`endif
            end else begin
                err_d       = 1'b1;
                seen_d[idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1_q  <= '0;
            an_s2_q  <= '0;
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            prev_q   <= '0;
            state_q  <= WAIT;
            cnt_q    <= '0;
            stage_q  <= '0;
            seen_q   <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
            stage_dp_q <= '0;
            dp_q       <= '0;
`endif
        end else begin
            an_s1_q  <= an;
            an_s2_q  <= an_s1_q;
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
            prev_q   <= key;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            seen_q   <= seen_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
`ifdef SEG_CAPTURE_DP_EN
            stage_dp_q <= stage_dp_d;
            dp_q       <= dp_d;
`endif
        end
    end

    assign value = value_q;
    assign valid = valid_q;
    assign err   = err_q;
`ifdef SEG_CAPTURE_DP_EN
    assign dp_out = dp_q;
`else
    assign dp_out = 4'b0000;
`endif
endmodule
